regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Multi-port integer register file for the pipelined RV32 core. Synchronous writes,
//  combinational reads, x0 hard-wired to zero, optional write-to-read bypass and a
//  per-register busy scoreboard. Decode reads it; two writeback lanes write it (ALU, LSU).
// PARAMETERS
//  DATA_WIDTH     32  bits per register
//  ADDRESS_WIDTH  5   register index width
//  NUM_REGS       32  registers (<= 2**ADDRESS_WIDTH)
//  NUM_RD         2   read ports
//  NUM_WR         2   write ports; higher index has priority
//  BYPASS         1   1: same-cycle write data is forwarded to reads; 0: old value is read
// PORTS
//  clk          in   1                       clock; all state updates on posedge
//  rst          in   1                       async reset, active-low
//  we           in   NUM_WR                  write enable per port
//  wr_addr      in   NUM_WR*ADDRESS_WIDTH    write index per port (packed, port 0 = LSBs)
//  wr_data      in   NUM_WR*DATA_WIDTH       write data per port
//  rd_addr      in   NUM_RD*ADDRESS_WIDTH    read index per port
//  rd_data      out  NUM_RD*DATA_WIDTH       read data per port
//  rd_busy      out  NUM_RD                  1 = rd_addr register has a pending producer
//  rsv_en       in   1                       reserve (mark busy) rsv_addr
//  rsv_addr     in   ADDRESS_WIDTH           register being reserved at issue
//  busy_vec     out  NUM_REGS                scoreboard state, bit i = reg i busy
// BEHAVIOUR
//  - Reset (rst=0, async): all registers and busy bits = 0; rd_data reads 0; rd_busy = 0.
//  - Write: on posedge, for each port p with we[p]=1 and wr_addr[p]!=0, reg <= wr_data[p].
//    Writes to x0 are dropped; x0 always reads 0 and is never busy.
//  - Same-address writes in one cycle: highest-index port's data lands; lower dropped.
//  - wr_addr >= NUM_REGS: write ignored. rd_addr >= NUM_REGS: rd_data = 0, rd_busy = 0.
//  - Read latency 0 (combinational). BYPASS=1: if any we[p]=1 with wr_addr[p]==rd_addr
//    (!=0), rd_data = that wr_data (highest p wins), rd_busy = 0 for that port.
//    BYPASS=0: rd_data = stored value; rd_busy reflects registered busy bit.
//  - Scoreboard per reg i!=0, next state:
//      set   = rsv_en && rsv_addr==i
//      clr   = any we[p] && wr_addr[p]==i
//      busy' = set ? 1 : (clr ? 0 : busy)   (set wins: new producer issued same cycle)
//    rsv_en with rsv_addr==0 has no effect.
//  - Reserve of an already-busy reg keeps it busy (no count; single outstanding producer
//    per reg assumed by issue logic; a later write clears it).
//  - Reset asserted mid-operation clears all state immediately; first posedge after
//    release behaves as cold start.
// STRUCTURE
//  - regfile_pkg: typedef reg_idx_t (ADDRESS_WIDTH), typedef xlen_t (DATA_WIDTH),
//    localparam ZERO_REG = 0, function for highest-priority write match.
//  - Sub-module regfile_scoreboard: busy bit array, rsv/clear logic, busy_vec output.
//  - Top: storage array, write-priority resolve, generate loop over NUM_RD read muxes.
// TESTING
//  1 Reset: fill regs, drop rst -> all rd_data=0, busy_vec=0 while rst=0, no clk edge needed.
//  2 x0: we[0]=1 wr_addr=0 data=32'hDEAD -> next cycle rd_addr=0 gives 0; rsv on x0 -> busy_vec[0]=0.
//  3 Dual write: port0 x5=32'h11, port1 x5=32'h22 same edge -> x5 reads 32'h22.
//  4 Bypass: BYPASS=1, x7=0, we[0]=1 x7=32'hA5 while rd_addr=7 -> rd_data=32'hA5 same cycle;
//    BYPASS=0 build -> 0 that cycle, 32'hA5 next.
//  5 Scoreboard: rsv x3 -> busy_vec[3]=1, rd_busy=1; write x3 -> 0; rsv+write x3 same
//    cycle -> stays 1.
//  6 Random: 10k cycles, all ports random vs reference model incl. out-of-range addresses.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared types, constants and the write-priority helper for the multi-port register file.
package regfile_mp_pkg;

  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int ZERO_REG  = 0;
  localparam int MAX_PORTS = 8;

  typedef logic [REG_AW-1:0]    reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;
  typedef logic [MAX_PORTS-1:0] port_mask_t;

  // Keeps only the highest set bit: the highest-index write port wins a collision.
  function automatic port_mask_t hi_onehot(input port_mask_t mask);
    hi_onehot = '0;
    for (int p = 0; p < MAX_PORTS; p++) begin
      if (mask[p]) begin
        hi_onehot    = '0;
        hi_onehot[p] = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/reserve bundle between the core (master) and the register file (slave).
interface regfile_mp_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int NUM_RD        = 2,
  parameter int NUM_WR        = 2
);
  logic [NUM_WR-1:0]                    we;
  logic [NUM_WR-1:0][ADDRESS_WIDTH-1:0] wr_addr;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wr_data;
  logic [NUM_RD-1:0][ADDRESS_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data;
  logic [NUM_RD-1:0]                    rd_busy;
  logic                                 rsv_en;
  logic [ADDRESS_WIDTH-1:0]             rsv_addr;
  logic [NUM_REGS-1:0]                  busy_vec;

  modport master (
    output we, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  we, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy bits: set by reserve at issue, cleared by any writeback to the reg.
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDRESS_WIDTH = REG_AW,
  parameter int NUM_REGS      = 32,
  parameter int NUM_WR        = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_WR-1:0]                    we,
  input  logic [NUM_WR-1:0][ADDRESS_WIDTH-1:0] wr_addr,
  input  logic                                 rsv_en,
  input  logic [ADDRESS_WIDTH-1:0]             rsv_addr,
  output logic [NUM_REGS-1:0]                  busy_vec
);

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // x0 is skipped so it can never become busy.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      set_vec[i] = rsv_en && (rsv_addr == ADDRESS_WIDTH'(i));
      for (int p = 0; p < NUM_WR; p++) begin
        if (we[p] && (wr_addr[p] == ADDRESS_WIDTH'(i))) clr_vec[i] = 1'b1;
      end
    end
  end

  // A reserve in the same cycle as a write means a new producer: set wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_vec <= '0;
    else      busy_vec <= set_vec | (busy_vec & ~clr_vec);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: synchronous writes, combinational reads,
// x0 hard-wired to zero, optional same-cycle write bypass and a busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH    = XLEN,
  parameter int ADDRESS_WIDTH = REG_AW,
  parameter int NUM_REGS      = 32,
  parameter int NUM_RD        = 2,
  parameter int NUM_WR        = 2,
  parameter bit BYPASS        = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] wr_val;
  logic [NUM_REGS-1:0]                 wr_hit;
  logic [NUM_REGS-1:0][MAX_PORTS-1:0]  wmatch;
  logic [NUM_REGS-1:0][MAX_PORTS-1:0]  wwin;
  logic [NUM_REGS-1:0]                 busy_vec;

  // Resolve which port (if any) lands in each register; out-of-range indices match nothing.
  always_comb begin
    wr_hit = '0;
    wr_val = '0;
    wmatch = '0;
    wwin   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        wmatch[i][p] = (i != ZERO_REG) && bus.we[p] && (bus.wr_addr[p] == ADDRESS_WIDTH'(i));
      end
      wwin[i]   = hi_onehot(wmatch[i]);
      wr_hit[i] = |wmatch[i];
      for (int p = 0; p < NUM_WR; p++) begin
        if (wwin[i][p]) wr_val[i] = bus.wr_data[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) regs[i] <= wr_val[i];
      end
    end
  end

  regfile_mp_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_REGS      (NUM_REGS),
    .NUM_WR        (NUM_WR)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (bus.we),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .busy_vec (busy_vec)
  );

  assign bus.busy_vec = busy_vec;

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    port_mask_t            bmatch;
    port_mask_t            bwin;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;

    // Reads are forced to zero while reset is held, including the bypass path.
    assign in_range = rst
                   && (bus.rd_addr[r] != ADDRESS_WIDTH'(ZERO_REG))
                   && ({1'b0, bus.rd_addr[r]} < (ADDRESS_WIDTH+1)'(NUM_REGS));

    always_comb begin
      bmatch = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        bmatch[p] = BYPASS && bus.we[p] && (bus.wr_addr[p] == bus.rd_addr[r]);
      end
      bwin = hi_onehot(bmatch);
      data = '0;
      busy = 1'b0;
      if (in_range) begin
        data = regs[bus.rd_addr[r]];
        busy = busy_vec[bus.rd_addr[r]];
        for (int p = 0; p < NUM_WR; p++) begin
          if (bwin[p]) begin
            data = bus.wr_data[p];
            busy = 1'b0;
          end
        end
      end
    end

    assign bus.rd_data[r] = data;
    assign bus.rd_busy[r] = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass builds driven in lockstep and checked
// against an array-based reference model through an expectation queue.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 28;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus1 ();
  regfile_mp_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus0 ();

  assign bus0.we       = bus1.we;
  assign bus0.wr_addr  = bus1.wr_addr;
  assign bus0.wr_data  = bus1.wr_data;
  assign bus0.rd_addr  = bus1.rd_addr;
  assign bus0.rsv_en   = bus1.rsv_en;
  assign bus0.rsv_addr = bus1.rsv_addr;

  regfile_mp #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  regfile_mp #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  // Reference state: plain arrays indexed by register number.
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];

  typedef struct {
    int                      tag;
    logic [NRD-1:0][DW-1:0]  d1;
    logic [NRD-1:0][DW-1:0]  d0;
    logic [NRD-1:0]          b1;
    logic [NRD-1:0]          b0;
    logic [NR-1:0]           bv;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   drv_done = 1'b0;

  function automatic void read_model(input int a, input bit byp, output logic [DW-1:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (rst && a != 0 && a < NR) begin
      d = m_regs[a];
      b = m_busy[a];
      if (byp) begin
        for (int p = 0; p < NWR; p++) begin
          if (bus1.we[p] && int'(bus1.wr_addr[p]) == a) begin
            d = bus1.wr_data[p];
            b = 1'b0;
          end
        end
      end
    end
  endfunction

  task automatic push_expect(input int tag);
    exp_t e;
    e.tag = tag;
    for (int r = 0; r < NRD; r++) begin
      read_model(int'(bus1.rd_addr[r]), 1'b1, e.d1[r], e.b1[r]);
      read_model(int'(bus1.rd_addr[r]), 1'b0, e.d0[r], e.b0[r]);
    end
    for (int i = 0; i < NR; i++) e.bv[i] = m_busy[i];
    q.push_back(e);
  endtask

  task automatic commit();
    int a;
    if (!rst) return;
    for (int p = 0; p < NWR; p++) begin
      a = int'(bus1.wr_addr[p]);
      if (bus1.we[p] && a != 0 && a < NR) begin
        m_regs[a] = bus1.wr_data[p];
        m_busy[a] = 1'b0;
      end
    end
    a = int'(bus1.rsv_addr);
    if (bus1.rsv_en && a != 0 && a < NR) m_busy[a] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic cycle(input int tag);
    push_expect(tag);
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic idle();
    bus1.we       = '0;
    bus1.wr_addr  = '0;
    bus1.wr_data  = '0;
    bus1.rsv_en   = 1'b0;
    bus1.rsv_addr = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    bus1.we[p]      = 1'b1;
    bus1.wr_addr[p] = AW'(a);
    bus1.wr_data[p] = d;
  endtask

  task automatic rsv(input int a);
    bus1.rsv_en   = 1'b1;
    bus1.rsv_addr = AW'(a);
  endtask

  task automatic chk(input string name, input int tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s tag=%0d got=%h expected=%h", name, tag, act, exp);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int r = 0; r < NRD; r++) begin
          chk($sformatf("byp_rd_data[%0d]", r), e.tag, 64'(bus1.rd_data[r]), 64'(e.d1[r]));
          chk($sformatf("byp_rd_busy[%0d]", r), e.tag, 64'(bus1.rd_busy[r]), 64'(e.b1[r]));
          chk($sformatf("nobyp_rd_data[%0d]", r), e.tag, 64'(bus0.rd_data[r]), 64'(e.d0[r]));
          chk($sformatf("nobyp_rd_busy[%0d]", r), e.tag, 64'(bus0.rd_busy[r]), 64'(e.b0[r]));
        end
        chk("byp_busy_vec", e.tag, 64'(bus1.busy_vec), 64'(e.bv));
        chk("nobyp_busy_vec", e.tag, 64'(bus0.busy_vec), 64'(e.bv));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog tag=-1 got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    bus1.rd_addr = '0;
    #1 do_reset();
    @(posedge clk);
    #1;
    cycle(0);
    rst = 1'b1;
    cycle(0);

    // 1: fill x1..x4, reserve x2, then drop reset between edges
    for (int i = 1; i <= 4; i++) begin
      idle();
      wr(0, i, $urandom | 32'h1);
      bus1.rd_addr[0] = AW'(i);
      cycle(1);
    end
    idle();
    rsv(2);
    cycle(1);
    idle();
    bus1.rd_addr[0] = AW'(1);
    bus1.rd_addr[1] = AW'(2);
    cycle(1);
    wr(1, 2, 32'hCAFE_F00D);
    do_reset();
    cycle(1);
    idle();
    rst = 1'b1;
    cycle(1);

    // 2: x0 writes and reserves are dropped
    wr(0, 0, 32'hDEAD);
    rsv(0);
    bus1.rd_addr = '0;
    cycle(2);
    idle();
    cycle(2);

    // 3: both ports hit x5 on the same edge
    wr(0, 5, 32'h11);
    wr(1, 5, 32'h22);
    cycle(3);
    idle();
    bus1.rd_addr[0] = AW'(5);
    cycle(3);

    // 4: write x7 while reading it
    bus1.rd_addr[0] = AW'(7);
    wr(0, 7, 32'hA5);
    cycle(4);
    idle();
    cycle(4);

    // 5: scoreboard reserve / clear / reserve+write
    bus1.rd_addr[0] = AW'(3);
    rsv(3);
    cycle(5);
    idle();
    cycle(5);
    wr(0, 3, 32'h33);
    cycle(5);
    idle();
    cycle(5);
    rsv(3);
    wr(1, 3, 32'h44);
    cycle(5);
    idle();
    cycle(5);

    // 6: random traffic including out-of-range indices and occasional reset pulses
    for (int c = 0; c < 10000; c++) begin
      idle();
      for (int p = 0; p < NWR; p++) begin
        if ($urandom_range(0, 1) == 1) wr(p, int'($urandom_range(0, 31)), $urandom);
      end
      if ($urandom_range(0, 7) == 0) bus1.wr_addr[1] = bus1.wr_addr[0];
      bus1.rsv_en   = ($urandom_range(0, 2) == 0);
      bus1.rsv_addr = AW'($urandom_range(0, 31));
      for (int r = 0; r < NRD; r++) begin
        bus1.rd_addr[r] = ($urandom_range(0, 3) == 0) ? bus1.wr_addr[r % NWR] : AW'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle(6);
      rst = 1'b1;
    end

    idle();
    drv_done = 1'b1;
  end

  initial begin
    wait (drv_done);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain tag=-1 got=%0d expected=0 pending", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
